idex_hazard_stage: RTL

- ID/EX pipeline register combined with load-use hazard detection.
- Latches decoded operands, register specifiers and control bits from ID.
- Feeds EX and the forwarding unit via idexrs, idexrt, idexrd, idexregwr and idexmemrd.
- Load-use hazards cannot be forwarded. This block detects them, freezes PC and IF/ID, and injects a one-cycle bubble.

---
 rtl/semimips_pkg.sv | 26 ++
 rtl/idex_hazard_stage_loaduse_detect.sv | 18 +
 rtl/idex_hazard_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/semimips_pkg.sv
// Shared pipeline definitions: datapath widths, the decoded control bundle and its
// bubble value. The forwarding unit and the EX/MEM register also use this package.
package semimips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 3;

    typedef struct packed {
        logic               regwr;
        logic               memtoreg;
        logic               memrd;
        logic               memwr;
        logic               alusrc;
        logic               regdst;
        logic [ALUOP_W-1:0] aluop;
    } ctl_bundle;

    // A bubble must never write the register file or memory.
    localparam ctl_bundle CTL_BUBBLE = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/idex_hazard_stage_loaduse_detect.sv
// Load-use comparator: the load in EX targets a register the instruction in ID reads.
// Register 0 is hardwired to zero, so it never creates a dependency.
module loaduse_detect #(
    parameter int REG_W = semimips_pkg::REG_W
) (
    input  logic             idexmemrd,
    input  logic             idexvalid,
    input  logic [REG_W-1:0] idexrt,
    input  logic [REG_W-1:0] ifidrs,
    input  logic [REG_W-1:0] ifidrt,
    output logic             loaduse
);

    // rt is compared even for I-type consumers; the rare extra stall is cheaper than decoding.
    assign loaduse = idexmemrd && idexvalid && (idexrt != '0) &&
                     ((idexrt == ifidrs) || (idexrt == ifidrt));

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and bubble injection.
// Define HAZARD_STATS_EN to add saturating load-use/flush event counters.
module idex_hazard_stage #(
    parameter int DATA_W  = semimips_pkg::DATA_W,
    parameter int REG_W   = semimips_pkg::REG_W,
    parameter int ALUOP_W = semimips_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memstall,
    input  logic               flush,
    input  logic [REG_W-1:0]   ifidrs,
    input  logic [REG_W-1:0]   ifidrt,
    input  logic [REG_W-1:0]   ifidrd,
    input  logic [DATA_W-1:0]  readdata1,
    input  logic [DATA_W-1:0]  readdata2,
    input  logic [DATA_W-1:0]  signimm,
    input  logic               ctl_regwr,
    input  logic               ctl_memtoreg,
    input  logic               ctl_memrd,
    input  logic               ctl_memwr,
    input  logic               ctl_alusrc,
    input  logic               ctl_regdst,
    input  logic [ALUOP_W-1:0] ctl_aluop,
    output logic [REG_W-1:0]   idexrs,
    output logic [REG_W-1:0]   idexrt,
    output logic [REG_W-1:0]   idexrd,
    output logic [DATA_W-1:0]  idexreaddata1,
    output logic [DATA_W-1:0]  idexreaddata2,
    output logic [DATA_W-1:0]  idexsignimm,
    output logic               idexregwr,
    output logic               idexmemtoreg,
    output logic               idexmemrd,
    output logic               idexmemwr,
    output logic               idexalusrc,
    output logic               idexregdst,
    output logic [ALUOP_W-1:0] idexaluop,
    output logic               idexvalid,
`ifdef HAZARD_STATS_EN
    input  logic               stats_clr,
    output logic [15:0]        luse_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic               pcwrite,
    output logic               ifidwrite
);

    import semimips_pkg::*;

    ctl_bundle ctl_in;
    ctl_bundle ctl_q;
    logic      valid_q;
    logic      loaduse;

    assign ctl_in = '{regwr:    ctl_regwr,
                      memtoreg: ctl_memtoreg,
                      memrd:    ctl_memrd,
                      memwr:    ctl_memwr,
                      alusrc:   ctl_alusrc,
                      regdst:   ctl_regdst,
                      aluop:    ctl_aluop};

    loaduse_detect #(.REG_W(REG_W)) u_loaduse_detect (
        .idexmemrd (ctl_q.memrd),
        .idexvalid (valid_q),
        .idexrt    (idexrt),
        .ifidrs    (ifidrs),
        .ifidrt    (ifidrt),
        .loaduse   (loaduse)
    );

    // Register state is zero during reset, so the only stall source to mask is memstall.
    assign pcwrite   = rst || !(loaduse || memstall);
    assign ifidwrite = pcwrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            idexrs        <= '0;
            idexrt        <= '0;
            idexrd        <= '0;
            idexreaddata1 <= '0;
            idexreaddata2 <= '0;
            idexsignimm   <= '0;
            ctl_q         <= CTL_BUBBLE;
            valid_q       <= 1'b0;
        end else if (!memstall) begin
            idexrs        <= ifidrs;
            idexrt        <= ifidrt;
            idexrd        <= ifidrd;
            idexreaddata1 <= readdata1;
            idexreaddata2 <= readdata2;
            idexsignimm   <= signimm;
            if (flush || loaduse) begin
                ctl_q   <= CTL_BUBBLE;
                valid_q <= 1'b0;
            end else begin
                ctl_q   <= ctl_in;
                valid_q <= 1'b1;
            end
        end
    end

    assign idexregwr    = ctl_q.regwr;
    assign idexmemtoreg = ctl_q.memtoreg;
    assign idexmemrd    = ctl_q.memrd;
    assign idexmemwr    = ctl_q.memwr;
    assign idexalusrc   = ctl_q.alusrc;
    assign idexregdst   = ctl_q.regdst;
    assign idexaluop    = ctl_q.aluop;
    assign idexvalid    = valid_q;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            luse_cnt  <= '0;
            flush_cnt <= '0;
        end else if (stats_clr) begin
            luse_cnt  <= '0;
            flush_cnt <= '0;
        end else if (!memstall) begin
            if (loaduse) luse_cnt  <= sat_inc16(luse_cnt);
            if (flush)   flush_cnt <= sat_inc16(flush_cnt);
        end
    end
`endif

endmodule
